// File: rtl/toggle_hs_rx.sv
// rtl/toggle_hs_rx.sv - two-phase toggle request receiver feeding a show-ahead ready/valid FIFO
module toggle_hs_rx #(
    parameter int DW          = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_t,
    input  logic [DW-1:0] data_in,
    output logic          ack_t,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [CW-1:0] count,
    output logic          full
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_seen_q, req_seen_d;
    logic                   ack_q, ack_d;
    logic [AW-1:0]          wptr_q, wptr_d;
    logic [AW-1:0]          rptr_q, rptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   full_q, full_d;
    logic                   valid_q, valid_d;
    logic [DW-1:0]          mem_q [DEPTH];

    logic req_s;
    logic pend;
    logic pop;
    logic space;
    logic push;

    assign req_s = sync_q[SYNC_STAGES-1];
    assign pend  = (req_s != req_seen_q);
    assign pop   = valid_q && dout_ready;
    // A pop at the same edge frees the slot the push needs, so a full FIFO still accepts.
    assign space = !full_q || pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pend && !space) state_d = S_WAIT;
            S_WAIT:  if (push)           state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        push = 1'b0;
        case (state_q)
            S_IDLE:  push = pend && space;
            S_WAIT:  push = pend && space;
            default: push = 1'b0;
        endcase
    end

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], req_t};
        req_seen_d = push ? req_s : req_seen_q;
        ack_d      = push ? ~ack_q : ack_q;
        wptr_d     = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d     = pop ? rptr_q + AW'(1) : rptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        full_d  = (count_d == CW'(DEPTH));
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= '0;
            req_seen_q <= 1'b0;
            ack_q      <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            req_seen_q <= req_seen_d;
            ack_q      <= ack_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            valid_q    <= valid_d;
        end
    end

    // Storage needs no reset: the empty flag masks stale entries on dout.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= data_in;
        end
    end

    assign ack_t      = ack_q;
    assign dout       = valid_q ? mem_q[rptr_q] : '0;
    assign dout_valid = valid_q;
    assign count      = count_q;
    assign full       = full_q;

endmodule

// File: tb/tb_toggle_hs_rx.sv
// tb/tb_toggle_hs_rx.sv - directed self-checking bench for toggle_hs_rx
module tb_toggle_hs_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_t;
    logic [7:0] data_in;
    logic       ack_t;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [2:0] count;
    logic       full;

    int total = 0;
    int bad   = 0;

    toggle_hs_rx #(.DW(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_t      (req_t),
        .data_in    (data_in),
        .ack_t      (ack_t),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .count      (count),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Toggle the request and wait (bounded) for the matching acknowledge.
    task automatic send(input logic [7:0] w);
        int n;
        data_in = w;
        req_t   = ~req_t;
        n = 0;
        while (ack_t !== req_t && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("send_ack", {31'd0, ack_t}, {31'd0, req_t});
    endtask

    initial begin
        int         ack_changes;
        logic       ack_prev;
        logic [7:0] rx_q[$];
        logic [7:0] next_w;
        int         sent;
        int         max_cnt;
        int         cyc;

        rst        = 1'b0;
        req_t      = 1'b1;
        data_in    = 8'h00;
        dout_ready = 1'b0;

        // Reset with an illegal high request, released with req_t low.
        step(3);
        chk("rst_ack",   {31'd0, ack_t},      32'd0);
        chk("rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_dout",  {24'd0, dout},       32'd0);
        chk("rst_count", {29'd0, count},      32'd0);
        chk("rst_full",  {31'd0, full},       32'd0);
        req_t = 1'b0;
        rst   = 1'b1;
        ack_changes = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (ack_t !== 1'b0) ack_changes++;
        end
        chk("rst_no_ack", ack_changes, 32'd0);
        chk("rst_count2", {29'd0, count}, 32'd0);

        // Single word: ack two edges after the sampling edge.
        data_in = 8'hA5;
        req_t   = 1'b1;
        step(1);
        chk("single_ack_n",   {31'd0, ack_t}, 32'd0);
        step(1);
        chk("single_ack_n1",  {31'd0, ack_t}, 32'd0);
        chk("single_valid0",  {31'd0, dout_valid}, 32'd0);
        step(1);
        chk("single_ack_n2",  {31'd0, ack_t}, 32'd1);
        chk("single_valid",   {31'd0, dout_valid}, 32'd1);
        chk("single_dout",    {24'd0, dout}, 32'hA5);
        chk("single_count",   {29'd0, count}, 32'd1);
        dout_ready = 1'b1;
        step(1);
        dout_ready = 1'b0;
        chk("single_pop_cnt", {29'd0, count}, 32'd0);
        chk("single_pop_dout",{24'd0, dout}, 32'd0);
        chk("single_pop_vld", {31'd0, dout_valid}, 32'd0);

        // Fill to full, then a fifth word must stall.
        for (int i = 1; i <= 4; i++) send(8'(i));
        chk("fill_full",  {31'd0, full},  32'd1);
        chk("fill_count", {29'd0, count}, 32'd4);
        chk("fill_ack",   {31'd0, ack_t}, 32'd1);
        data_in     = 8'h05;
        req_t       = ~req_t;
        ack_prev    = ack_t;
        ack_changes = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (ack_t !== ack_prev) ack_changes++;
        end
        chk("bp_no_ack", ack_changes, 32'd0);
        chk("bp_count",  {29'd0, count}, 32'd4);
        chk("bp_head",   {24'd0, dout}, 32'h01);
        dout_ready = 1'b1;
        step(1);
        chk("bp_ack_at_pop", {31'd0, ack_t}, {31'd0, req_t});
        chk("bp_count_pop",  {29'd0, count}, 32'd4);
        chk("bp_full_pop",   {31'd0, full},  32'd1);
        for (int i = 2; i <= 5; i++) begin
            chk("bp_order", {24'd0, dout}, 32'(i));
            step(1);
        end
        dout_ready = 1'b0;
        chk("bp_drained", {29'd0, count}, 32'd0);

        // Streaming 12 words with a consumer that is always ready.
        dout_ready = 1'b1;
        next_w  = 8'h10;
        sent    = 0;
        max_cnt = 0;
        cyc     = 0;
        while (rx_q.size() < 12 && cyc < 400) begin
            if (dout_valid) rx_q.push_back(dout);
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (ack_t === req_t && sent < 12) begin
                data_in = next_w;
                req_t   = ~req_t;
                next_w  = next_w + 8'd1;
                sent++;
            end
            step(1);
            cyc++;
        end
        dout_ready = 1'b0;
        chk("wrap_received", rx_q.size(), 32'd12);
        for (int i = 0; i < rx_q.size(); i++) begin
            chk("wrap_order", {24'd0, rx_q[i]}, 32'h10 + 32'(i));
        end
        chk("wrap_max_le2", {31'd0, (max_cnt <= 2)}, 32'd1);

        // Reset in the middle of a transfer.
        send(8'h31);
        send(8'h32);
        send(8'h33);
        chk("mid_count3", {29'd0, count}, 32'd3);
        data_in = 8'h34;
        req_t   = ~req_t;
        step(1);
        rst   = 1'b0;
        req_t = 1'b0;
        #1;
        chk("mid_async_count", {29'd0, count},      32'd0);
        chk("mid_async_ack",   {31'd0, ack_t},      32'd0);
        chk("mid_async_valid", {31'd0, dout_valid}, 32'd0);
        step(2);
        rst = 1'b1;
        step(3);
        chk("mid_post_count", {29'd0, count}, 32'd0);
        send(8'h77);
        chk("mid_new_ack",   {31'd0, ack_t},      32'd1);
        chk("mid_new_valid", {31'd0, dout_valid}, 32'd1);
        chk("mid_new_dout",  {24'd0, dout},       32'h77);
        chk("mid_new_count", {29'd0, count},      32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
